// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing defaults and FSM state type for the pixel serialiser.
package ws2812_pkg;

    localparam int T_BIT_DEF = 15;
    localparam int T0H_DEF   = 5;
    localparam int T1H_DEF   = 10;
    localparam int PIX_W     = 24;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/write_pixel_if.sv
// Pixel request/status bundle between the frame sequencer and the serialiser.
// Handshake: valid is sampled only while busy=0; one frame starts per acceptance,
// r/g/b are captured at that edge and busy stays high until the last bit ends.
interface write_pixel_if;

    logic       valid;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       data_out;
    logic       busy;

    modport master (
        output valid, r, g, b,
        input  data_out, busy
    );

    modport slave (
        input  valid, r, g, b,
        output data_out, busy
    );

endinterface

// File: rtl/write_pixel_bit_timer.sv
// Per-bit cycle counter; reports the last cycle of a bit and the next-cycle line level.
module write_pixel_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T_BIT = T_BIT_DEF,
    parameter int T0H   = T0H_DEF,
    parameter int T1H   = T1H_DEF
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic en_i,
    input  logic bit_i,
    output logic bit_done_o,
    output logic hi_o
);

    localparam int CW = $clog2(T_BIT);
    localparam logic [CW-1:0] LAST_C = CW'(T_BIT - 1);
    localparam logic [CW-1:0] T0H_C  = CW'(T0H);
    localparam logic [CW-1:0] T1H_C  = CW'(T1H);

    logic [CW-1:0] cyc_q;
    logic [CW-1:0] cyc_d;

    assign bit_done_o = en_i && (cyc_q == LAST_C);

    always_comb begin
        cyc_d = '0;
        if (en_i && !bit_done_o) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    // Level is judged on the next count so the registered line lines up with it.
    assign hi_o = (cyc_d < (bit_i ? T1H_C : T0H_C));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

endmodule

// File: rtl/write_pixel.sv
// Serialises one latched {g,r,b} pixel MSB-first onto a WS2812 data line.
module write_pixel
    import ws2812_pkg::*;
#(
    parameter int T_BIT = T_BIT_DEF,
    parameter int T0H   = T0H_DEF,
    parameter int T1H   = T1H_DEF
) (
    input  logic          CLK,
    input  logic          RSTN,
    write_pixel_if.slave  px,
    output state_e        state_o
);

    state_e            state_q;
    state_e            state_d;
    logic [PIX_W-1:0]  sr_q;
    logic [PIX_W-1:0]  sr_d;
    logic [4:0]        bit_q;
    logic [4:0]        bit_d;
    logic              data_q;
    logic              data_d;
    logic              busy_q;
    logic              busy_d;
    logic              bit_done;
    logic              hi;

    write_pixel_bit_timer #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_timer (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .en_i       (state_q == SEND),
        .bit_i      (sr_d[PIX_W-1]),
        .bit_done_o (bit_done),
        .hi_o       (hi)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (px.valid) begin
                    sr_d    = {px.g, px.r, px.b};
                    bit_d   = 5'd23;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bit_done) begin
                    if (bit_q != 5'd0) begin
                        sr_d  = {sr_q[PIX_W-2:0], 1'b0};
                        bit_d = bit_q - 5'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are computed from next state so they register with no input-to-output path.
        busy_d = (state_d == SEND);
        data_d = busy_d && hi;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign px.data_out = data_q;
    assign px.busy     = busy_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_write_pixel.sv
// Bench for write_pixel: vector table, corner sequences and random pixels vs a waveform model.
module tb_write_pixel;
  import ws2812_pkg::*;

  localparam int BIT_CYC = 15;
  localparam int SHORT_H = 5;
  localparam int LONG_H  = 10;
  localparam int FRAME   = 24 * BIT_CYC;
  localparam int CAP_MAX = 400;

  logic   CLK = 1'b0;
  logic   RSTN = 1'b0;
  state_e state_o;

  write_pixel_if px();

  write_pixel dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .px      (px),
    .state_o (state_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    int         exp_long;
    int         exp_high;
    int         exp_first;
  } vec_t;

  vec_t vecs[5];
  int   total = 0;
  int   bad = 0;
  logic cap [0:CAP_MAX-1];
  int   cap_n;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference line level: bit i of the frame is pixel bit 23-i, high for 10 or 5 of its 15 cycles.
  function automatic logic model_level(input logic [23:0] pix, input int cyc);
    int   idx;
    int   c;
    logic bv;
    idx = cyc / BIT_CYC;
    c   = cyc % BIT_CYC;
    bv  = pix[23 - idx];
    return c < (bv ? LONG_H : SHORT_H);
  endfunction

  task automatic start_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    @(negedge CLK);
    px.g = g;
    px.r = r;
    px.b = b;
    px.valid = 1'b1;
    @(posedge CLK);
  endtask

  // Records data_out every cycle while busy; returns at the first busy=0 sample.
  task automatic capture(input bit hold, input int scramble_at);
    cap_n = 0;
    for (int i = 0; i < CAP_MAX; i++) begin
      @(negedge CLK);
      if (!px.busy) break;
      cap[cap_n] = px.data_out;
      cap_n++;
      if (!hold && i == 0) px.valid = 1'b0;
      if (i == scramble_at) begin
        px.g = 8'($urandom);
        px.r = 8'($urandom);
        px.b = 8'($urandom);
      end
    end
  endtask

  task automatic decode(output int longs, output int highs, output int first_long);
    int run;
    int pulse_idx;
    longs = 0;
    highs = 0;
    first_long = -1;
    run = 0;
    pulse_idx = 0;
    for (int i = 0; i <= cap_n; i++) begin
      if (i < cap_n && cap[i]) begin
        run++;
        highs++;
      end else if (run > 0) begin
        if (run == LONG_H) begin
          if (first_long < 0) first_long = pulse_idx * BIT_CYC;
          longs++;
        end
        pulse_idx++;
        run = 0;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [23:0] pix);
    int errs;
    errs = 0;
    for (int i = 0; i < cap_n; i++) begin
      if (cap[i] !== model_level(pix, i)) errs++;
    end
    check({tag, " busy_len"}, cap_n, FRAME);
    check({tag, " wave_err"}, errs, 0);
  endtask

  initial begin
    int longs;
    int highs;
    int first;
    logic [23:0] pix;

    vecs[0] = '{g: 8'h40, r: 8'h00, b: 8'h00, exp_long: 1,  exp_high: 125, exp_first: 15};
    vecs[1] = '{g: 8'hFF, r: 8'hFF, b: 8'hFF, exp_long: 24, exp_high: 240, exp_first: 0};
    vecs[2] = '{g: 8'h00, r: 8'h00, b: 8'h00, exp_long: 0,  exp_high: 120, exp_first: -1};
    vecs[3] = '{g: 8'h08, r: 8'h08, b: 8'h80, exp_long: 3,  exp_high: 135, exp_first: 60};
    vecs[4] = '{g: 8'hA5, r: 8'h3C, b: 8'h0F, exp_long: 12, exp_high: 180, exp_first: 0};

    // Reset held with valid asserted: nothing may start.
    px.valid = 1'b1;
    px.g = 8'hFF;
    px.r = 8'hFF;
    px.b = 8'hFF;
    #1;
    check("rst busy", int'(px.busy), 0);
    check("rst data", int'(px.data_out), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst held busy", int'(px.busy), 0);
    check("rst state", int'(state_o), int'(IDLE));
    px.valid = 1'b0;
    RSTN = 1'b1;
    repeat (4) @(negedge CLK);
    check("post rst idle busy", int'(px.busy), 0);
    check("post rst idle data", int'(px.data_out), 0);

    // Vector table: single-pulse valid, decoded pulse statistics and full waveform.
    foreach (vecs[k]) begin
      start_pixel(vecs[k].g, vecs[k].r, vecs[k].b);
      capture(1'b0, -1);
      check_frame($sformatf("vec%0d", k), {vecs[k].g, vecs[k].r, vecs[k].b});
      decode(longs, highs, first);
      check($sformatf("vec%0d longs", k), longs, vecs[k].exp_long);
      check($sformatf("vec%0d highs", k), highs, vecs[k].exp_high);
      check($sformatf("vec%0d first_long", k), first, vecs[k].exp_first);
      repeat (2) @(negedge CLK);
    end

    // Held valid with inputs changed mid-frame: latched values must win.
    start_pixel(8'h08, 8'h08, 8'h80);
    cap_n = 0;
    for (int i = 0; i < CAP_MAX; i++) begin
      @(negedge CLK);
      if (!px.busy) break;
      cap[cap_n] = px.data_out;
      cap_n++;
      if (i == 50) begin
        px.g = 8'h00;
        px.r = 8'h00;
        px.b = 8'h00;
      end
    end
    px.valid = 1'b0;
    check_frame("held_change", 24'h080880);
    repeat (3) @(negedge CLK);
    check("held_change no restart", int'(px.busy), 0);

    // Reset during bit 7 aborts at once; next request sends a fresh frame.
    start_pixel(8'hFF, 8'hFF, 8'hFF);
    @(negedge CLK);
    px.valid = 1'b0;
    repeat (7 * BIT_CYC + 2) @(negedge CLK);
    check("pre abort data", int'(px.data_out), 1);
    #2 RSTN = 1'b0;
    #1;
    check("abort busy", int'(px.busy), 0);
    check("abort data", int'(px.data_out), 0);
    check("abort state", int'(state_o), int'(IDLE));
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    check("post abort idle", int'(px.busy), 0);
    start_pixel(8'h12, 8'h34, 8'h56);
    capture(1'b0, -1);
    check_frame("after_abort", 24'h123456);

    // Valid held across two frames: second starts after exactly one idle cycle.
    repeat (2) @(negedge CLK);
    start_pixel(8'h5A, 8'hC3, 8'h81);
    capture(1'b1, -1);
    check_frame("b2b first", 24'h5AC381);
    capture(1'b0, -1);
    check_frame("b2b second", 24'h5AC381);

    // Random pixels, random hold and mid-frame input scrambling.
    for (int n = 0; n < 8; n++) begin
      bit hold;
      repeat ($urandom_range(1, 4)) @(negedge CLK);
      pix  = 24'($urandom);
      hold = 1'($urandom_range(0, 1));
      start_pixel(pix[23:16], pix[15:8], pix[7:0]);
      capture(hold, int'($urandom_range(0, FRAME - 1)));
      px.valid = 1'b0;
      check_frame($sformatf("rand%0d", n), pix);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
